// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, one bit per clock, LSB first.
// Optional zero flag output enabled by defining SERIAL_SUB_ZF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo
`ifdef SERIAL_SUB_ZF_EN
  ,
  output logic             zf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bo;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_nx;
  logic [WIDTH-1:0] w_res_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs
  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_br_nx  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_res_nx = {w_d, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_diff <= '0;
      r_bo   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_br  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_nx;
        r_cnt <= r_cnt + 1'b1;
        r_res <= w_res_nx[WIDTH-1:1];
      end
      if (w_last) begin
        r_diff <= w_res_nx;
        r_bo   <= w_br_nx;
      end
    end
  end

`ifdef SERIAL_SUB_ZF_EN
  logic r_zf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zf <= 1'b0;
    end else if (w_last) begin
      r_zf <= (w_res_nx == '0);
    end
  end

  assign zf = r_zf;
`endif

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign diff = r_diff;
  assign bo   = r_bo;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub at WIDTH=8 and WIDTH=4.
// Define SERIAL_SUB_ZF_EN to also check the zero flag.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       s8  = 1'b0;
  logic       s4  = 1'b0;
  logic [7:0] a8  = '0;
  logic [7:0] b8  = '0;
  logic [3:0] a4  = '0;
  logic [3:0] b4  = '0;

  logic       busy8, done8, bo8;
  logic [7:0] diff8;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;
`ifdef SERIAL_SUB_ZF_EN
  logic       zf8, zf4;
`endif

  serial_sub #(.WIDTH(8)) u8 (
    .clk  (clk),
    .rst  (rst),
    .start(s8),
    .a    (a8),
    .b    (b8),
    .busy (busy8),
    .done (done8),
    .diff (diff8),
    .bo   (bo8)
`ifdef SERIAL_SUB_ZF_EN
    ,
    .zf   (zf8)
`endif
  );

  serial_sub #(.WIDTH(4)) u4 (
    .clk  (clk),
    .rst  (rst),
    .start(s4),
    .a    (a4),
    .b    (b4),
    .busy (busy4),
    .done (done4),
    .diff (diff4),
    .bo   (bo4)
`ifdef SERIAL_SUB_ZF_EN
    ,
    .zf   (zf4)
`endif
  );

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       bo;
    logic       z;
    int         de;
  } exp_t;

  exp_t q[$];
  int   e       = 0;
  int   free_e  = 0;
  int   rst_e   = -1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] last_d[2];
  logic       last_bo[2];
`ifdef SERIAL_SUB_ZF_EN
  logic       last_z[2];
`endif

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h",
               nm, k, e, act, req);
    end
  endtask

  // Reference: an accepted op yields (a-b) mod 2^W, a<b, W edges later
  always @(posedge clk) begin
    exp_t x;
    int   w;
    e = e + 1;
    if (rst) begin
      q.delete();
      free_e = e + 1;
      rst_e  = e;
    end else if ((s8 || s4) && e >= free_e) begin
      w    = s8 ? 8 : 4;
      x.id = s8 ? 0 : 1;
      if (s8) begin
        x.d  = a8 - b8;
        x.bo = (a8 < b8);
      end else begin
        x.d  = {4'h0, 4'(a4 - b4)};
        x.bo = (a4 < b4);
      end
      x.z  = (x.d == 8'h00);
      x.de = e + w;
      q.push_back(x);
      free_e = e + w + 1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_e == e) begin
      for (int k = 0; k < 2; k++) begin
        last_d[k]  = '0;
        last_bo[k] = 1'b0;
`ifdef SERIAL_SUB_ZF_EN
        last_z[k]  = 1'b0;
`endif
      end
    end
    for (int k = 0; k < 2; k++) begin
      logic       dn, bs, bo_o, exp_bs;
      logic [7:0] df;
      exp_t       x;
      dn   = (k == 0) ? done8 : done4;
      bs   = (k == 0) ? busy8 : busy4;
      bo_o = (k == 0) ? bo8 : bo4;
      df   = (k == 0) ? diff8 : {4'h0, diff4};
      if (q.size() > 0 && q[0].id == k && e > q[0].de) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout dut%0d: no done by edge %0d", k, q[0].de);
        void'(q.pop_front());
      end
      if (dn) begin
        if (q.size() == 0 || q[0].id != k) begin
          chk("spurious_done", k, 32'(dn), 32'(0));
        end else begin
          x = q.pop_front();
          chk("latency", k, e, x.de);
          chk("diff", k, 32'(df), 32'(x.d));
          chk("bo", k, 32'(bo_o), 32'(x.bo));
          last_d[k]  = x.d;
          last_bo[k] = x.bo;
`ifdef SERIAL_SUB_ZF_EN
          chk("zf", k, 32'((k == 0) ? zf8 : zf4), 32'(x.z));
          last_z[k] = x.z;
`endif
        end
      end else begin
        chk("hold_diff", k, 32'(df), 32'(last_d[k]));
        chk("hold_bo", k, 32'(bo_o), 32'(last_bo[k]));
`ifdef SERIAL_SUB_ZF_EN
        chk("hold_zf", k, 32'((k == 0) ? zf8 : zf4), 32'(last_z[k]));
`endif
      end
      exp_bs = (q.size() > 0 && q[0].id == k && e < q[0].de);
      chk("busy", k, 32'(bs), 32'(exp_bs));
    end
  end

  task automatic go(input int k, input logic [7:0] x, input logic [7:0] y);
    @(posedge clk); #2;
    if (k == 0) begin
      a8 = x; b8 = y; s8 = 1'b1;
    end else begin
      a4 = x[3:0]; b4 = y[3:0]; s4 = 1'b1;
    end
    @(posedge clk); #2;
    s8 = 1'b0;
    s4 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    a4 = 4'($urandom);
    b4 = 4'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    go(0, 8'h05, 8'h03); drain();
    go(0, 8'h03, 8'h05); drain();
    go(0, 8'h00, 8'h01); drain();
    go(0, 8'hA7, 8'hA7); drain();
    go(0, 8'h00, 8'h00); drain();
    go(0, 8'hFF, 8'h00); drain();

    // reset wins over start on the same edge
    @(posedge clk); #2;
    rst = 1'b1; s8 = 1'b1; a8 = 8'h44; b8 = 8'h11;
    @(posedge clk); #2;
    rst = 1'b0; s8 = 1'b0;
    repeat (12) @(posedge clk);

    // abort at the 4th RUN edge
    go(0, 8'h5A, 8'h33);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(posedge clk);
    go(0, 8'h10, 8'h01); drain();

    // start held high, operands churning every cycle
    @(posedge clk); #2;
    s8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
    end
    s8 = 1'b0;
    drain();

    for (int i = 0; i < 20; i++) begin
      go(0, 8'($urandom), 8'($urandom));
      drain();
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        go(1, 8'(x), 8'(y));
        drain();
      end
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
